// File: rtl/ps2_mouse_rx_pkg.sv
// Shared constants, byte-0 field map and helpers for the PS/2 mouse receiver.
package ps2_mouse_rx_pkg;
    localparam int FRAME_BITS = 11;

    localparam int B0_L     = 0;
    localparam int B0_R     = 1;
    localparam int B0_M     = 2;
    localparam int B0_ONE   = 3;
    localparam int B0_XSIGN = 4;
    localparam int B0_YSIGN = 5;
    localparam int B0_XOVF  = 6;
    localparam int B0_YOVF  = 7;

    localparam logic [11:0] X_RST = 12'd320;
    localparam logic [11:0] Y_RST = 12'd240;

    typedef enum logic [1:0] {BYTE0, BYTE1, BYTE2} byte_idx_t;

    function automatic logic [11:0] clamp_coord(input logic signed [12:0] v,
                                                input logic signed [12:0] vmax);
        if (v < 13'sd0) return 12'd0;
        if (v > vmax) return vmax[11:0];
        return v[11:0];
    endfunction
endpackage

// File: rtl/ps2_mouse_rx_if.sv
// PS/2 line inputs and decoded cursor/button outputs of the mouse receiver.
interface ps2_mouse_rx_if;
    logic        PS2_CLK;
    logic        PS2_DATA;
    logic [11:0] XCOORD;
    logic [11:0] YCOORD;
    logic        L_BUTTON;
    logic        R_BUTTON;
    logic        M_BUTTON;
    logic        PKT_VALID;
    logic        FRAME_ERR;

    modport master (output PS2_CLK, PS2_DATA,
                    input  XCOORD, YCOORD, L_BUTTON, R_BUTTON, M_BUTTON, PKT_VALID, FRAME_ERR);
    modport slave  (input  PS2_CLK, PS2_DATA,
                    output XCOORD, YCOORD, L_BUTTON, R_BUTTON, M_BUTTON, PKT_VALID, FRAME_ERR);
endinterface

// File: rtl/ps2_byte_rx.sv
// PS/2 byte receiver: line sync, clock deglitch, 11-bit frame shifter, parity and idle timeout.
module ps2_byte_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       pkt_busy,
    output logic [7:0] rx_byte,
    output logic       byte_strobe,
    output logic       err_strobe
);
    localparam int GW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync, dat_sync;
    logic [7:0]    clk_hist;
    logic [3:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [GW-1:0] gap;
    logic          fall;
    logic          din;

    // Oldest sample in bit 7: four highs followed by four lows marks one clean falling edge.
    assign fall = (clk_hist == 8'hF0);
    assign din  = dat_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync    <= 2'b11;
            dat_sync    <= 2'b11;
            clk_hist    <= 8'hFF;
            bit_cnt     <= 4'd0;
            shreg       <= 8'd0;
            par_bit     <= 1'b0;
            gap         <= '0;
            rx_byte     <= 8'd0;
            byte_strobe <= 1'b0;
            err_strobe  <= 1'b0;
        end else begin
            clk_sync    <= {clk_sync[0], ps2_clk};
            dat_sync    <= {dat_sync[0], ps2_data};
            clk_hist    <= {clk_hist[6:0], clk_sync[1]};
            byte_strobe <= 1'b0;
            err_strobe  <= 1'b0;
            if (fall) begin
                gap <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!din) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shreg   <= {din, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'(FRAME_BITS - 2)) begin
                    par_bit <= din;
                    bit_cnt <= 4'(FRAME_BITS - 1);
                end else begin
                    bit_cnt <= 4'd0;
                    if (din && (^{shreg, par_bit})) begin
                        rx_byte     <= shreg;
                        byte_strobe <= 1'b1;
                    end else begin
                        err_strobe <= 1'b1;
                    end
                end
            end else if (bit_cnt != 4'd0 || pkt_busy) begin
                if (gap == GW'(TIMEOUT_CYC)) begin
                    err_strobe <= 1'b1;
                    bit_cnt    <= 4'd0;
                    gap        <= '0;
                end else begin
                    gap <= gap + 1'b1;
                end
            end else begin
                gap <= '0;
            end
        end
    end
endmodule

// File: rtl/ps2_mouse_rx.sv
// PS/2 mouse receiver top: 3-byte packet assembly and clamped cursor accumulation.
module ps2_mouse_rx
    import ps2_mouse_rx_pkg::*;
#(
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic          CLK_50MHZ,
    input  logic          MASTER_RST,
    ps2_mouse_rx_if.slave bus
);
    localparam logic signed [12:0] X_LIM = 13'(X_MAX);
    localparam logic signed [12:0] Y_LIM = 13'(Y_MAX);

    logic [7:0]         rx_byte;
    logic               byte_strobe, err_strobe;
    byte_idx_t          idx, idx_nxt;
    logic               load_b0, load_b1, pkt_done, sync_err;
    logic [2:0]         btn_pend;
    logic               x_sign, y_sign, x_ovf, y_ovf;
    logic [7:0]         b1;
    logic [11:0]        x_q, y_q;
    logic [2:0]         btn_q;
    logic               pkt_valid_q, frame_err_q;
    logic signed [12:0] dx, dy, nx, ny;

    ps2_byte_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_byte_rx (
        .clk         (CLK_50MHZ),
        .rst         (MASTER_RST),
        .ps2_clk     (bus.PS2_CLK),
        .ps2_data    (bus.PS2_DATA),
        .pkt_busy    (idx != BYTE0),
        .rx_byte     (rx_byte),
        .byte_strobe (byte_strobe),
        .err_strobe  (err_strobe)
    );

    always_comb begin
        idx_nxt  = idx;
        load_b0  = 1'b0;
        load_b1  = 1'b0;
        pkt_done = 1'b0;
        sync_err = 1'b0;
        if (err_strobe) begin
            idx_nxt = BYTE0;
        end else if (byte_strobe) begin
            case (idx)
                // A header without the always-one bit means we are mid-packet; drop it and resync.
                BYTE0: if (rx_byte[B0_ONE]) begin
                    load_b0 = 1'b1;
                    idx_nxt = BYTE1;
                end else begin
                    sync_err = 1'b1;
                end
                BYTE1: begin
                    load_b1 = 1'b1;
                    idx_nxt = BYTE2;
                end
                default: begin
                    pkt_done = 1'b1;
                    idx_nxt  = BYTE0;
                end
            endcase
        end
    end

    // Byte 2 is consumed straight off rx_byte in the cycle the packet completes.
    always_comb begin
        dx = x_ovf ? 13'sd0 : $signed({{4{x_sign}}, x_sign, b1});
        dy = y_ovf ? 13'sd0 : $signed({{4{y_sign}}, y_sign, rx_byte});
        nx = $signed({1'b0, x_q}) + dx;
        ny = $signed({1'b0, y_q}) - dy;
    end

    always_ff @(posedge CLK_50MHZ or posedge MASTER_RST) begin
        if (MASTER_RST) begin
            idx         <= BYTE0;
            btn_pend    <= 3'd0;
            x_sign      <= 1'b0;
            y_sign      <= 1'b0;
            x_ovf       <= 1'b0;
            y_ovf       <= 1'b0;
            b1          <= 8'd0;
            x_q         <= X_RST;
            y_q         <= Y_RST;
            btn_q       <= 3'd0;
            pkt_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            idx         <= idx_nxt;
            pkt_valid_q <= pkt_done;
            frame_err_q <= err_strobe | sync_err;
            if (load_b0) begin
                btn_pend <= {rx_byte[B0_M], rx_byte[B0_R], rx_byte[B0_L]};
                x_sign   <= rx_byte[B0_XSIGN];
                y_sign   <= rx_byte[B0_YSIGN];
                x_ovf    <= rx_byte[B0_XOVF];
                y_ovf    <= rx_byte[B0_YOVF];
            end
            if (load_b1) b1 <= rx_byte;
            if (pkt_done) begin
                x_q   <= clamp_coord(nx, X_LIM);
                y_q   <= clamp_coord(ny, Y_LIM);
                btn_q <= btn_pend;
            end
        end
    end

    assign bus.XCOORD    = x_q;
    assign bus.YCOORD    = y_q;
    assign bus.L_BUTTON  = btn_q[0];
    assign bus.R_BUTTON  = btn_q[1];
    assign bus.M_BUTTON  = btn_q[2];
    assign bus.PKT_VALID = pkt_valid_q;
    assign bus.FRAME_ERR = frame_err_q;
endmodule
